sprite_mixer: RTL and testbench
===============================

SPRITE_MIXER -- requirements
Module: sprite_mixer

Interface
REQ-001 SHALL have parameter NSPR, default 4: number of sprite inputs (1..8).
REQ-002 SHALL have parameter SPR_DATAW, default 4: bits per colour index for sprites and background.
REQ-003 SHALL have parameter COLRW, default 12: palette entry width, RGB 4:4:4 packed {R,G,B}.
REQ-004 SHALL have port clk  input  1: single clock for the whole block.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port frame  input  1: one-cycle pulse at start of frame.
REQ-007 SHALL have port de  input  1: display enable, high in the active area.
REQ-008 SHALL have port bg_pix  input  SPR_DATAW: background colour index.
REQ-009 SHALL have port spr_pix  input  NSPR*SPR_DATAW: packed sprite indices, sprite 0 at LSBs.
REQ-010 SHALL have port spr_drawing  input  NSPR: per-sprite drawing flags, bit i = sprite i.
REQ-011 SHALL have ports pal_we input 1, pal_addr input SPR_DATAW, pal_data input COLRW: palette write request.
REQ-012 SHALL have port pal_busy  output  1: a palette write is pending commit.
REQ-013 SHALL have port rgb  output  COLRW: final pixel colour.
REQ-014 SHALL have port de_o  output  1: de delayed to align with rgb.
REQ-015 SHALL have port collision  output  NSPR: sticky per-sprite collision flags.
REQ-016 SHALL have port coll_clr  input  1: clears collision flags.

Function
REQ-017 A sprite SHALL be opaque in a cycle iff spr_drawing[i]=1 and its index is nonzero; index 0 is transparent.
REQ-018 Stage 1 SHALL register sel_idx = index of the lowest-numbered opaque sprite, else bg_pix, plus de_d1 = de.
REQ-019 Stage 2 SHALL register rgb = palette[sel_idx] when de_d1=1, else 0, and de_o = de_d1.
REQ-020 Latency from (de, indices) to (rgb, de_o) SHALL be exactly 2 cycles, with no bubbles.
REQ-021 Palette SHALL be 2**SPR_DATAW x COLRW, one write port, one registered read port; read of the address written in the same cycle SHALL return old data.
REQ-022 Write FSM states: IDLE, PEND. IDLE with pal_we and de=0: write at next edge, stay IDLE.
REQ-023 IDLE with pal_we and de=1: capture addr/data into pending buffer, go PEND, pal_busy=1 from next cycle.
REQ-024 PEND with de=0: commit buffer, go IDLE, pal_busy=0 next cycle; the palette SHALL never change while de=1.
REQ-025 PEND with pal_we: buffer overwritten (last write wins), stay PEND; if also de=0, the new request is committed directly and FSM goes IDLE.
REQ-026 Collision: when de=1 and two or more sprites are opaque, every opaque sprite's collision bit SHALL set at the next edge.
REQ-027 collision bits SHALL clear on frame or coll_clr; simultaneous set and clear SHALL leave the new set bits high.

Reset
REQ-028 rst SHALL force rgb=0, de_o=0, de_d1=0, sel_idx=0, pal_busy=0, collision=0, FSM=IDLE, and drop any pending write.
REQ-029 Palette contents SHALL NOT be reset; rst priority SHALL exceed all other inputs.

Configuration
REQ-030 Macro SPRITE_MIXER_COLLISION_EN defined: REQ-026/027 logic SHALL be present.
REQ-031 Macro undefined: collision SHALL be constant 0, coll_clr ignored, no collision flops synthesised.

Verification
REQ-032 de=0, pal_we, addr 3, data 12'hF00; then de=1, bg_pix=3 -> rgb=12'hF00 two cycles later, de_o aligned.
REQ-033 spr_drawing=4'b0110, spr1=5, spr2=7, pal[5]=12'h0F0 -> rgb=12'h0F0 (sprite 1 wins).
REQ-034 spr_drawing=4'b0001, spr0=0, bg_pix=2, pal[2]=12'h00F -> rgb=12'h00F (transparent).
REQ-035 de=1, pal_we addr 2 data 12'hFFF -> pal_busy=1, rgb unchanged until de=0; then pal_busy=0 and pal[2]=12'hFFF.
REQ-036 COLLISION_EN: sprites 0 and 3 opaque with de=1 -> collision=4'b1001; frame pulse -> 4'b0000.
REQ-037 rst asserted in PEND -> pal_busy=0 next cycle, pending write never committed.

Source files
------------

// File: rtl/sprite_mixer.sv
// Two-stage sprite priority mixer with a 2**SPR_DATAW-entry palette whose writes are deferred to blanking.
// Define SPRITE_MIXER_COLLISION_EN to build the sticky per-sprite collision flags.
module sprite_mixer #(
   parameter int NSPR      = 4,
   parameter int SPR_DATAW = 4,
   parameter int COLRW     = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      frame,
   input  logic                      de,
   input  logic [SPR_DATAW-1:0]      bg_pix,
   input  logic [NSPR*SPR_DATAW-1:0] spr_pix,
   input  logic [NSPR-1:0]           spr_drawing,
   input  logic                      pal_we,
   input  logic [SPR_DATAW-1:0]      pal_addr,
   input  logic [COLRW-1:0]          pal_data,
   output logic                      pal_busy,
   output logic [COLRW-1:0]          rgb,
   output logic                      de_o,
   output logic [NSPR-1:0]           collision,
   input  logic                      coll_clr
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PEND = 1'b1;

   logic [COLRW-1:0]     r_palette [2**SPR_DATAW];
   logic [SPR_DATAW-1:0] r_sel_idx;
   logic                 r_de_d1;
   logic [COLRW-1:0]     r_rgb;
   logic                 r_de_o;
   logic [0:0]           r_state;
   logic [SPR_DATAW-1:0] r_pend_addr;
   logic [COLRW-1:0]     r_pend_data;

   logic [NSPR-1:0]      w_opaque;
   logic                 w_multi;
   logic [SPR_DATAW-1:0] w_sel;
   logic [0:0]           w_state_nxt;
   logic                 w_pend_load;
   logic                 w_wr_en;
   logic [SPR_DATAW-1:0] w_wr_addr;
   logic [COLRW-1:0]     w_wr_data;

   // Iterating downwards lets the lowest-numbered opaque sprite overwrite the others.
   always_comb begin
      logic w_found;
      w_opaque = '0;
      w_multi  = 1'b0;
      w_sel    = bg_pix;
      w_found  = 1'b0;
      for (int i = 0; i < NSPR; i++) begin
         w_opaque[i] = spr_drawing[i] && (spr_pix[i*SPR_DATAW +: SPR_DATAW] != '0);
         if (w_opaque[i]) begin
            if (w_found) w_multi = 1'b1;
            w_found = 1'b1;
         end
      end
      for (int i = NSPR-1; i >= 0; i--) begin
         if (w_opaque[i]) w_sel = spr_pix[i*SPR_DATAW +: SPR_DATAW];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pend_load = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_addr   = pal_addr;
      w_wr_data   = pal_data;
      if (r_state == IDLE) begin
         if (pal_we && de) begin
            w_pend_load = 1'b1;
            w_state_nxt = PEND;
         end else if (pal_we) begin
            w_wr_en = 1'b1;
         end
      end else begin
         if (pal_we && !de) begin
            w_wr_en     = 1'b1;
            w_state_nxt = IDLE;
         end else if (pal_we) begin
            w_pend_load = 1'b1;
         end else if (!de) begin
            w_wr_en     = 1'b1;
            w_wr_addr   = r_pend_addr;
            w_wr_data   = r_pend_data;
            w_state_nxt = IDLE;
         end
      end
   end

   // Palette contents survive reset; only the write strobe is blocked.
   always_ff @(posedge clk) begin
      if (w_wr_en && !rst) r_palette[w_wr_addr] <= w_wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pend_addr <= '0;
         r_pend_data <= '0;
         r_sel_idx   <= '0;
         r_de_d1     <= 1'b0;
         r_rgb       <= '0;
         r_de_o      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pend_load) begin
            r_pend_addr <= pal_addr;
            r_pend_data <= pal_data;
         end
         r_sel_idx <= w_sel;
         r_de_d1   <= de;
         r_rgb     <= r_de_d1 ? r_palette[r_sel_idx] : '0;
         r_de_o    <= r_de_d1;
      end
   end

   assign pal_busy = (r_state == PEND);
   assign rgb      = r_rgb;
   assign de_o     = r_de_o;

`ifdef SPRITE_MIXER_COLLISION_EN
   logic [NSPR-1:0] r_collision;
   logic [NSPR-1:0] w_coll_set;

   // New hits are OR-ed in after the clear so a same-cycle hit survives.
   assign w_coll_set = (de && w_multi) ? w_opaque : '0;

   always_ff @(posedge clk) begin
      if (rst) r_collision <= '0;
      else     r_collision <= (r_collision & ~{NSPR{frame | coll_clr}}) | w_coll_set;
   end

   assign collision = r_collision;
`else
   logic w_unused;
   assign w_unused  = ^{frame, coll_clr, w_multi};
   assign collision = '0;
`endif

endmodule

// File: tb/tb_sprite_mixer.sv
// Directed self-checking bench for sprite_mixer; collision checks follow SPRITE_MIXER_COLLISION_EN.
module tb_sprite_mixer;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame;
   logic        de;
   logic [3:0]  bg_pix;
   logic [15:0] spr_pix;
   logic [3:0]  spr_drawing;
   logic        pal_we;
   logic [3:0]  pal_addr;
   logic [11:0] pal_data;
   logic        pal_busy;
   logic [11:0] rgb;
   logic        de_o;
   logic [3:0]  collision;
   logic        coll_clr;

   int checks = 0;
   int errors = 0;

   sprite_mixer #(.NSPR(4), .SPR_DATAW(4), .COLRW(12)) dut (
      .clk(clk), .rst(rst), .frame(frame), .de(de), .bg_pix(bg_pix),
      .spr_pix(spr_pix), .spr_drawing(spr_drawing), .pal_we(pal_we),
      .pal_addr(pal_addr), .pal_data(pal_data), .pal_busy(pal_busy),
      .rgb(rgb), .de_o(de_o), .collision(collision), .coll_clr(coll_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic d, input logic [3:0] bg,
                                input logic [15:0] sp, input logic [3:0] drw);
      de          = d;
      bg_pix      = bg;
      spr_pix     = sp;
      spr_drawing = drw;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic palWrite(input logic [3:0] a, input logic [11:0] d);
      pal_we = 1'b1; pal_addr = a; pal_data = d;
      tick();
      pal_we = 1'b0;
   endtask

   initial begin
      rst = 1'b1; frame = 1'b0; coll_clr = 1'b0; pal_we = 1'b0;
      pal_addr = '0; pal_data = '0;
      applyStimulus(1'b0, 4'd0, 16'h0000, 4'b0000);
      tick(); tick();
      checkOutput("reset_rgb", 32'(rgb), 32'h000);
      checkOutput("reset_de_o", 32'(de_o), 32'h0);
      checkOutput("reset_busy", 32'(pal_busy), 32'h0);
      checkOutput("reset_coll", 32'(collision), 32'h0);
      rst = 1'b0;

      // Blanking writes land immediately
      palWrite(4'd3, 12'hF00);
      checkOutput("idle_write_busy", 32'(pal_busy), 32'h0);
      palWrite(4'd5, 12'h0F0);
      palWrite(4'd2, 12'h00F);

      // Three-pixel stream: background, sprite priority, transparent sprite
      applyStimulus(1'b1, 4'd3, 16'h0000, 4'b0000);
      tick();
      checkOutput("lat_de_o_early", 32'(de_o), 32'h0);
      applyStimulus(1'b1, 4'd0, 16'h0750, 4'b0110);
      tick();
      checkOutput("bg_rgb", 32'(rgb), 32'hF00);
      checkOutput("bg_de_o", 32'(de_o), 32'h1);
      applyStimulus(1'b1, 4'd2, 16'h0000, 4'b0001);
      tick();
      checkOutput("prio_rgb", 32'(rgb), 32'h0F0);
      applyStimulus(1'b0, 4'd0, 16'h0000, 4'b0000);
      tick();
      checkOutput("transp_rgb", 32'(rgb), 32'h00F);
      tick();
      checkOutput("blank_rgb", 32'(rgb), 32'h000);
      checkOutput("blank_de_o", 32'(de_o), 32'h0);

      // Write during active area is held until blanking
      applyStimulus(1'b1, 4'd2, 16'h0000, 4'b0000);
      palWrite(4'd2, 12'hFFF);
      checkOutput("pend_busy", 32'(pal_busy), 32'h1);
      tick();
      checkOutput("pend_rgb_old1", 32'(rgb), 32'h00F);
      tick();
      checkOutput("pend_rgb_old2", 32'(rgb), 32'h00F);
      checkOutput("pend_busy2", 32'(pal_busy), 32'h1);
      applyStimulus(1'b0, 4'd2, 16'h0000, 4'b0000);
      tick();
      checkOutput("commit_busy", 32'(pal_busy), 32'h0);
      checkOutput("commit_read_old", 32'(rgb), 32'h00F);
      applyStimulus(1'b1, 4'd2, 16'h0000, 4'b0000);
      tick(); tick();
      checkOutput("commit_new_data", 32'(rgb), 32'hFFF);

      // Last pending write wins
      applyStimulus(1'b1, 4'd4, 16'h0000, 4'b0000);
      palWrite(4'd4, 12'h111);
      palWrite(4'd4, 12'h222);
      checkOutput("lww_busy", 32'(pal_busy), 32'h1);
      applyStimulus(1'b0, 4'd4, 16'h0000, 4'b0000);
      tick();
      applyStimulus(1'b1, 4'd4, 16'h0000, 4'b0000);
      tick(); tick();
      checkOutput("lww_rgb", 32'(rgb), 32'h222);

      // New request in PEND during blanking is committed directly
      palWrite(4'd6, 12'h333);
      applyStimulus(1'b0, 4'd6, 16'h0000, 4'b0000);
      palWrite(4'd6, 12'h444);
      checkOutput("direct_busy", 32'(pal_busy), 32'h0);
      applyStimulus(1'b1, 4'd6, 16'h0000, 4'b0000);
      tick(); tick();
      checkOutput("direct_rgb", 32'(rgb), 32'h444);

      // Collision set, frame clear, set-beats-clear, single sprite no set
      applyStimulus(1'b1, 4'd0, 16'h5005, 4'b1001);
      tick();
`ifdef SPRITE_MIXER_COLLISION_EN
      checkOutput("coll_set", 32'(collision), 32'h9);
`else
      checkOutput("coll_off_set", 32'(collision), 32'h0);
`endif
      applyStimulus(1'b0, 4'd0, 16'h0000, 4'b0000);
      frame = 1'b1;
      tick();
      frame = 1'b0;
      checkOutput("coll_frame_clr", 32'(collision), 32'h0);
      applyStimulus(1'b1, 4'd0, 16'h5005, 4'b1001);
      coll_clr = 1'b1;
      tick();
`ifdef SPRITE_MIXER_COLLISION_EN
      checkOutput("coll_set_wins", 32'(collision), 32'h9);
`else
      checkOutput("coll_off_clr", 32'(collision), 32'h0);
`endif
      applyStimulus(1'b1, 4'd0, 16'h0005, 4'b1001);
      tick();
      coll_clr = 1'b0;
      checkOutput("coll_single", 32'(collision), 32'h0);

      // Reset while pending drops the write
      applyStimulus(1'b1, 4'd2, 16'h0000, 4'b0000);
      palWrite(4'd2, 12'h0AA);
      checkOutput("rstpend_busy", 32'(pal_busy), 32'h1);
      rst = 1'b1;
      tick();
      checkOutput("rstpend_busy_clr", 32'(pal_busy), 32'h0);
      checkOutput("rstpend_rgb", 32'(rgb), 32'h000);
      rst = 1'b0;
      applyStimulus(1'b0, 4'd2, 16'h0000, 4'b0000);
      tick();
      applyStimulus(1'b1, 4'd2, 16'h0000, 4'b0000);
      tick(); tick();
      checkOutput("rstpend_dropped", 32'(rgb), 32'hFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
